// File: rtl/pht_pkg.sv
// Shared definitions for the pattern history table.
//   pht_state_e : table state, sweeping INIT or serving READY
//   sat_next    : saturating counter step, width given at the call site
//   PHT_DEF_*   : default counter width and initial counter value
package pht_pkg;

    typedef enum logic [0:0] {
        PHT_INIT  = 1'b0,
        PHT_READY = 1'b1
    } pht_state_e;

    localparam int PHT_DEF_CTR_W = 2;
    localparam logic [PHT_DEF_CTR_W-1:0] PHT_DEF_INIT_VAL = {PHT_DEF_CTR_W{1'b1}};

    // Saturating step of a ctr_w-bit counter, carried in 32 bits so one
    // function serves every counter width. ctr must already fit in ctr_w bits.
    function automatic logic [31:0] sat_next(
        input logic [31:0] ctr,
        input logic        taken,
        input int unsigned ctr_w
    );
        logic [31:0] max_v;
        logic [31:0] res;
        max_v = (32'd1 << ctr_w) - 32'd1;
        if (taken) begin
            if (ctr >= max_v) begin
                res = max_v;
            end else begin
                res = ctr + 32'd1;
            end
        end else begin
            if (ctr == 32'd0) begin
                res = 32'd0;
            end else begin
                res = ctr - 32'd1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pht_sat_ctr_next.sv
// Combinational saturating increment/decrement of one counter.
// Also usable wherever a hysteresis counter is needed (e.g. BTB).
//   i_ctr      : current counter value
//   i_taken    : 1 = count up, 0 = count down
//   o_ctr_next : next value, clamped to [0, 2^CTR_W-1]
module pht_sat_ctr_next
    import pht_pkg::*;
#(
    parameter int CTR_W = PHT_DEF_CTR_W
)(
    input  logic [CTR_W-1:0] i_ctr,
    input  logic             i_taken,
    output logic [CTR_W-1:0] o_ctr_next
);

    assign o_ctr_next = CTR_W'(sat_next(32'(i_ctr), i_taken, CTR_W));

endmodule

// File: rtl/pht_counter_table.sv
// Pattern history table: ENTRIES saturating CTR_W-bit direction counters.
// One registered prediction read port, one update port, optional gshare
// indexing and an init/clear sweep that writes INIT_VAL to every entry.
//   clk, resetn         : clock, synchronous active-low reset
//   clear_req           : re-initialise all counters and the history
//   ready               : table initialised, requests accepted
//   pred_valid/pc_idx   : prediction request
//   pred_resp_valid     : response valid one cycle after an accepted request
//   pred_taken/ctr/idx  : counter MSB, counter value, final index used
//   upd_valid/idx/taken : resolved-branch update of one counter
//   ghr                 : global history, LSB = newest resolved outcome
module pht_counter_table
    import pht_pkg::*;
#(
    parameter int               ENTRIES  = 256,
    parameter int               CTR_W    = PHT_DEF_CTR_W,
    parameter logic [CTR_W-1:0] INIT_VAL = {CTR_W{1'b1}},
    parameter bit               GSHARE   = 1'b1,
    localparam int              IDX_W    = $clog2(ENTRIES)
)(
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear_req,
    output logic             ready,
    input  logic             pred_valid,
    input  logic [IDX_W-1:0] pred_pc_idx,
    output logic             pred_resp_valid,
    output logic             pred_taken,
    output logic [CTR_W-1:0] pred_ctr,
    output logic [IDX_W-1:0] pred_idx,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    output logic [IDX_W-1:0] ghr
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    pht_state_e       r_state;
    pht_state_e       w_state_nxt;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic [CTR_W-1:0] r_ctr [ENTRIES];
    logic [IDX_W-1:0] r_ghr;

    logic             r_resp_valid;
    logic             r_pred_taken;
    logic [CTR_W-1:0] r_pred_ctr;
    logic [IDX_W-1:0] r_pred_idx;

    logic             w_ready;
    logic [IDX_W-1:0] w_lkp_idx;
    logic             w_pred_acc;
    logic             w_upd_en;
    logic [CTR_W-1:0] w_upd_cur;
    logic [CTR_W-1:0] w_upd_nxt;
    logic [CTR_W-1:0] w_rd_ctr;
    logic             w_wr_en;
    logic [IDX_W-1:0] w_wr_idx;
    logic [CTR_W-1:0] w_wr_data;

    assign w_ready    = (r_state == PHT_READY);
    // Lookup hashes with the history as it stood before this cycle's update.
    assign w_lkp_idx  = GSHARE ? (pred_pc_idx ^ r_ghr) : pred_pc_idx;
    assign w_pred_acc = w_ready & pred_valid;
    // A clear in the same cycle wins over the update.
    assign w_upd_en   = w_ready & upd_valid & ~clear_req;
    assign w_upd_cur  = r_ctr[upd_idx];

    pht_sat_ctr_next #(
        .CTR_W      (CTR_W)
    ) u_sat (
        .i_ctr      (w_upd_cur),
        .i_taken    (upd_taken),
        .o_ctr_next (w_upd_nxt)
    );

    // Write-to-read bypass: a same-index update is visible to the lookup.
    assign w_rd_ctr = (w_upd_en && (upd_idx == w_lkp_idx)) ? w_upd_nxt : r_ctr[w_lkp_idx];

    // State register and sweep pointer
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= PHT_INIT;
            r_ptr   <= {IDX_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Next-state logic: sweep every entry once, then serve until cleared
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            PHT_INIT: begin
                if (clear_req) begin
                    w_ptr_nxt = {IDX_W{1'b0}};
                end else if (r_ptr == LAST_IDX) begin
                    w_state_nxt = PHT_READY;
                    w_ptr_nxt   = {IDX_W{1'b0}};
                end else begin
                    w_ptr_nxt = r_ptr + IDX_W'(1'b1);
                end
            end
            PHT_READY: begin
                if (clear_req) begin
                    w_state_nxt = PHT_INIT;
                    w_ptr_nxt   = {IDX_W{1'b0}};
                end else begin
                    w_state_nxt = PHT_READY;
                end
            end
            default: begin
                w_state_nxt = PHT_INIT;
                w_ptr_nxt   = {IDX_W{1'b0}};
            end
        endcase
    end

    // Single table write port, shared by the sweep and the update path
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_idx  = {IDX_W{1'b0}};
        w_wr_data = {CTR_W{1'b0}};
        case (r_state)
            PHT_INIT: begin
                w_wr_en   = 1'b1;
                w_wr_idx  = r_ptr;
                w_wr_data = INIT_VAL;
            end
            PHT_READY: begin
                w_wr_en   = w_upd_en;
                w_wr_idx  = upd_idx;
                w_wr_data = w_upd_nxt;
            end
            default: begin
                w_wr_en = 1'b0;
            end
        endcase
    end

    // Counter array; contents need no reset because the sweep rewrites them
    always_ff @(posedge clk) begin
        if (resetn && w_wr_en) begin
            r_ctr[w_wr_idx] <= w_wr_data;
        end
    end

    // Global history: shifted by resolved branches only, zeroed by a clear
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ghr <= {IDX_W{1'b0}};
        end else if (w_ready && clear_req) begin
            r_ghr <= {IDX_W{1'b0}};
        end else if (w_upd_en) begin
            r_ghr <= (r_ghr << 1) | IDX_W'(upd_taken);
        end else begin
            r_ghr <= r_ghr;
        end
    end

    // Prediction response registers; data holds while no request is accepted
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_resp_valid <= 1'b0;
            r_pred_taken <= 1'b0;
            r_pred_ctr   <= {CTR_W{1'b0}};
            r_pred_idx   <= {IDX_W{1'b0}};
        end else begin
            r_resp_valid <= w_pred_acc;
            if (w_pred_acc) begin
                r_pred_taken <= w_rd_ctr[CTR_W-1];
                r_pred_ctr   <= w_rd_ctr;
                r_pred_idx   <= w_lkp_idx;
            end
        end
    end

    assign ready           = w_ready;
    assign pred_resp_valid = r_resp_valid;
    assign pred_taken      = r_pred_taken;
    assign pred_ctr        = r_pred_ctr;
    assign pred_idx        = r_pred_idx;
    assign ghr             = r_ghr;

endmodule

// File: tb/tb_pht_counter_table.sv
// Self-checking bench for pht_counter_table (ENTRIES=256, CTR_W=2, gshare on).
// A behavioural model of the table is advanced at every rising edge and
// compared with the DUT on every falling edge; directed sections add literal
// expectations for the init length, saturation, bypass, gshare and clear.
module tb_pht_counter_table;

    localparam int ENTRIES = 256;
    localparam int CTR_MAX = 3;

    logic       clk = 1'b0;
    logic       resetn;
    logic       clear_req;
    logic       ready;
    logic       pred_valid;
    logic [7:0] pred_pc_idx;
    logic       pred_resp_valid;
    logic       pred_taken;
    logic [1:0] pred_ctr;
    logic [7:0] pred_idx;
    logic       upd_valid;
    logic [7:0] upd_idx;
    logic       upd_taken;
    logic [7:0] ghr;

    always #5 clk = ~clk;

    pht_counter_table #(
        .ENTRIES  (256),
        .CTR_W    (2),
        .INIT_VAL (2'b11),
        .GSHARE   (1'b1)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .clear_req       (clear_req),
        .ready           (ready),
        .pred_valid      (pred_valid),
        .pred_pc_idx     (pred_pc_idx),
        .pred_resp_valid (pred_resp_valid),
        .pred_taken      (pred_taken),
        .pred_ctr        (pred_ctr),
        .pred_idx        (pred_idx),
        .upd_valid       (upd_valid),
        .upd_idx         (upd_idx),
        .upd_taken       (upd_taken),
        .ghr             (ghr)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: counter values as plain integers, history as an
    // integer, and a count of cycles remaining until the table is usable.
    int m_ctr [ENTRIES];
    int m_ghr  = 0;
    int m_busy = ENTRIES;
    int exp_rv    = 0;
    int exp_ctr   = 0;
    int exp_taken = 0;
    int exp_idx   = 0;
    bit chk_en    = 1'b0;

    function automatic void chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_fill();
        for (int i = 0; i < ENTRIES; i++) m_ctr[i] = CTR_MAX;
    endfunction

    // What the table does at one rising edge, given the inputs now applied.
    function automatic void model_step();
        int li;
        int nv;
        if (!resetn) begin
            m_busy = ENTRIES;
            m_ghr  = 0;
            model_fill();
            exp_rv = 0; exp_ctr = 0; exp_taken = 0; exp_idx = 0;
        end else if (m_busy > 0) begin
            exp_rv = 0;
            if (clear_req) m_busy = ENTRIES;
            else           m_busy = m_busy - 1;
        end else begin
            li = int'(pred_pc_idx) ^ m_ghr;
            if (upd_valid && !clear_req) begin
                nv = m_ctr[upd_idx];
                if (upd_taken) nv = (nv >= CTR_MAX) ? CTR_MAX : nv + 1;
                else           nv = (nv <= 0) ? 0 : nv - 1;
                m_ctr[upd_idx] = nv;
                m_ghr = ((m_ghr * 2) + (upd_taken ? 1 : 0)) % ENTRIES;
            end
            if (pred_valid) begin
                exp_rv    = 1;
                exp_ctr   = m_ctr[li];
                exp_taken = (exp_ctr >= 2) ? 1 : 0;
                exp_idx   = li;
            end else begin
                exp_rv = 0;
            end
            if (clear_req) begin
                m_busy = ENTRIES;
                m_ghr  = 0;
                model_fill();
            end
        end
    endfunction

    // Continuous comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready",      int'(ready),           (m_busy == 0) ? 1 : 0);
            chk("resp_valid", int'(pred_resp_valid), exp_rv);
            chk("pred_ctr",   int'(pred_ctr),        exp_ctr);
            chk("pred_taken", int'(pred_taken),      exp_taken);
            chk("pred_idx",   int'(pred_idx),        exp_idx);
            chk("ghr",        int'(ghr),             m_ghr);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        chk_en = 1'b1;
        #1;
    endtask

    task automatic idle();
        clear_req   = 1'b0;
        pred_valid  = 1'b0;
        pred_pc_idx = 8'h00;
        upd_valid   = 1'b0;
        upd_idx     = 8'h00;
        upd_taken   = 1'b0;
    endtask

    // Random traffic until ready rises (bounded); returns cycles counted.
    task automatic wait_ready(output int n);
        n = 0;
        do begin
            pred_valid  = 1'($urandom_range(0, 1));
            pred_pc_idx = 8'($urandom);
            upd_valid   = 1'($urandom_range(0, 1));
            upd_idx     = 8'($urandom);
            upd_taken   = 1'($urandom_range(0, 1));
            tick();
            n++;
        end while (!ready && n < 400);
        idle();
    endtask

    // Predict the table entry tidx under the current model history.
    task automatic predict_entry(input int tidx);
        pred_valid  = 1'b1;
        pred_pc_idx = 8'(tidx ^ m_ghr);
        tick();
        pred_valid  = 1'b0;
    endtask

    int n;
    int sat_exp [9] = '{2, 1, 0, 0, 1, 2, 3, 3, 3};
    int sat_dir [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 1};

    initial begin
        resetn = 1'b0;
        idle();
        model_fill();

        // Reset and initial sweep
        tick();
        tick();
        resetn = 1'b1;
        wait_ready(n);
        chk("init_len", n, 256);
        for (int i = 0; i < ENTRIES; i++) begin
            pred_valid  = 1'b1;
            pred_pc_idx = 8'(i);
            tick();
            chk("init_entry", int'(pred_ctr), 3);
            chk("init_taken", int'(pred_taken), 1);
        end
        idle();

        // Saturation on entry 5
        for (int k = 0; k < 9; k++) begin
            upd_valid = 1'b1;
            upd_idx   = 8'd5;
            upd_taken = 1'(sat_dir[k]);
            tick();
            upd_valid = 1'b0;
            predict_entry(5);
            chk("sat_ctr", int'(pred_ctr), sat_exp[k]);
            chk("sat_idx", int'(pred_idx), 5);
        end

        // Same-cycle predict and update on entry 7
        pred_valid  = 1'b1;
        pred_pc_idx = 8'(7 ^ m_ghr);
        upd_valid   = 1'b1;
        upd_idx     = 8'd7;
        upd_taken   = 1'b0;
        tick();
        idle();
        chk("bypass_valid", int'(pred_resp_valid), 1);
        chk("bypass_ctr",   int'(pred_ctr), 2);
        chk("bypass_taken", int'(pred_taken), 1);

        // Clear with a simultaneous update
        clear_req = 1'b1;
        upd_valid = 1'b1;
        upd_idx   = 8'd5;
        upd_taken = 1'b0;
        tick();
        idle();
        chk("clear_ready", int'(ready), 0);
        chk("clear_ghr",   int'(ghr), 0);
        wait_ready(n);
        chk("clear_len", n, 256);
        predict_entry(5);
        chk("clear_entry5", int'(pred_ctr), 3);
        predict_entry(7);
        chk("clear_entry7", int'(pred_ctr), 3);

        // Gshare index formation
        upd_valid = 1'b1;
        upd_idx   = 8'h20;
        upd_taken = 1'b1; tick();
        upd_taken = 1'b1; tick();
        upd_taken = 1'b0; tick();
        idle();
        chk("gshare_ghr", int'(ghr), 8'h06);
        pred_valid  = 1'b1;
        pred_pc_idx = 8'h0F;
        tick();
        idle();
        chk("gshare_idx", int'(pred_idx), 8'h09);

        // Reset in the middle of a sweep (pointer at 100)
        clear_req = 1'b1;
        tick();
        idle();
        repeat (100) tick();
        resetn     = 1'b0;
        pred_valid = 1'b1;
        tick();
        resetn = 1'b1;
        idle();
        wait_ready(n);
        chk("midsweep_len", n, 256);

        // Reset while a request is in flight discards the response
        pred_valid  = 1'b1;
        pred_pc_idx = 8'h44;
        resetn      = 1'b0;
        tick();
        chk("rst_discard", int'(pred_resp_valid), 0);
        resetn = 1'b1;
        idle();
        wait_ready(n);
        chk("rst_len", n, 256);

        // Random traffic, concentrated on a few entries
        for (int c = 0; c < 4000; c++) begin
            pred_valid  = 1'($urandom_range(0, 1));
            pred_pc_idx = ($urandom_range(0, 1) == 0) ? 8'($urandom)
                                                      : 8'($urandom_range(0, 7) ^ m_ghr);
            upd_valid   = 1'($urandom_range(0, 1));
            upd_idx     = 8'($urandom_range(0, 7));
            upd_taken   = 1'($urandom_range(0, 1));
            clear_req   = ($urandom_range(0, 299) == 0);
            resetn      = ($urandom_range(0, 1999) != 0);
            tick();
        end
        resetn = 1'b1;
        idle();
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
